// File: rtl/usart_tx_pkg.sv
// Shared types and constants for the USART transmit frame controller.
// FRAME_BITS grows to 11 when USART_TX_PARITY_EN is defined.
package usart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    STOP   = 3'd4,
    PARITY = 3'd5
  } tx_state_t;

  localparam int DATA_BITS = 8;

`ifdef USART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/usart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the last
// (tick) and second-to-last (pre_tick) cycle of each period.
module usart_baud_tick #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick     = (cnt == LAST);
  assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/usart_tx_frame_ctrl.sv
// USART transmit frame controller driving an external 8-bit PISO register.
// Optional even-parity bit between data and stop: define USART_TX_PARITY_EN.
module usart_tx_frame_ctrl
  import usart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 9
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_VALID,
  output logic       DATA_READY,
  output logic [7:0] PAR_OUT,
  output logic       SHIFT_MODE,
  output logic       SR_CE,
  input  logic       SERIAL_IN,
  output logic       TX_LINE,
  output logic       BUSY,
  output logic       DONE
);

  localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);
  localparam bit         PARITY_SLOT = (FRAME_BITS > DATA_BITS + 2);

  tx_state_t  state;
  logic [2:0] bit_cnt;
  logic       tick;
  logic       pre_tick;
  logic       restart;

  // Holding the counter at zero until START begins aligns every bit period
  // to the state transitions.
  assign restart = (state == IDLE) || (state == LOAD);

  usart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk     (CLK),
    .rst     (CLR),
    .restart (restart),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  // Pulse outputs (SR_CE, DONE) are set on pre_tick so that, being
  // registered, they are high exactly in the last cycle of a bit period.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      TX_LINE    <= LINE_IDLE;
      DATA_READY <= 1'b1;
      PAR_OUT    <= '0;
      SHIFT_MODE <= 1'b0;
      SR_CE      <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      SR_CE <= 1'b0;
      DONE  <= 1'b0;
      case (state)
        IDLE: begin
          TX_LINE <= LINE_IDLE;
          if (DATA_VALID) begin
            PAR_OUT    <= DATA_IN;
            DATA_READY <= 1'b0;
            SR_CE      <= 1'b1;
            SHIFT_MODE <= 1'b0;
            BUSY       <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          TX_LINE    <= LINE_IDLE;
          SHIFT_MODE <= 1'b1;
          bit_cnt    <= '0;
          state      <= START;
        end
        START: begin
          TX_LINE <= LINE_START;
          if (tick) begin
            state <= DATA;
          end
        end
        DATA: begin
          TX_LINE <= SERIAL_IN;
          if (pre_tick && bit_cnt != LAST_BIT) begin
            SR_CE <= 1'b1;
          end
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              state <= PARITY_SLOT ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef USART_TX_PARITY_EN
        PARITY: begin
          TX_LINE <= ^PAR_OUT;
          if (tick) begin
            state <= STOP;
          end
        end
`endif
        STOP: begin
          TX_LINE <= LINE_IDLE;
          if (pre_tick) begin
            DONE <= 1'b1;
          end
          if (tick) begin
            state      <= IDLE;
            DATA_READY <= 1'b1;
            BUSY       <= 1'b0;
            SHIFT_MODE <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          TX_LINE    <= LINE_IDLE;
          DATA_READY <= 1'b1;
          BUSY       <= 1'b0;
          SHIFT_MODE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usart_tx_frame_ctrl.sv
// Directed bench for usart_tx_frame_ctrl with a behavioural 8-bit PISO.
// Optional parity checks are compiled in with USART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_usart_tx_frame_ctrl;

  localparam int CPB = 4;
`ifdef USART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int FC = FRAME * CPB;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [7:0] DATA_IN = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       DATA_READY;
  logic [7:0] PAR_OUT;
  logic       SHIFT_MODE;
  logic       SR_CE;
  logic       SERIAL_IN;
  logic       TX_LINE;
  logic       BUSY;
  logic       DONE;

  logic [7:0] sr = 8'h00;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  usart_tx_frame_ctrl #(.CLKS_PER_BIT(CPB), .CNT_W(3)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .DATA_IN   (DATA_IN),
    .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY),
    .PAR_OUT   (PAR_OUT),
    .SHIFT_MODE(SHIFT_MODE),
    .SR_CE     (SR_CE),
    .SERIAL_IN (SERIAL_IN),
    .TX_LINE   (TX_LINE),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always @(posedge CLK) begin
    if (SR_CE) sr <= SHIFT_MODE ? {1'b0, sr[7:1]} : PAR_OUT;
  end
  assign SERIAL_IN = sr[0];

  // Expected line level n cycles after the accepting edge.
  function automatic logic exp_line(input logic [7:0] b, input int n);
    if (n < 2) return 1'b1;
    if (n < 2 + CPB) return 1'b0;
    if (n < 2 + 9 * CPB) return b[(n - 2 - CPB) / CPB];
`ifdef USART_TX_PARITY_EN
    if (n < 2 + 10 * CPB) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset();
    CLR = 1'b1;
    DATA_VALID = 1'b1;
    DATA_IN = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_LINE !== 1'b1 || DATA_READY !== 1'b1 || BUSY !== 1'b0 || SR_CE !== 1'b0 ||
          DONE !== 1'b0 || PAR_OUT !== 8'h00 || SHIFT_MODE !== 1'b0) begin
        errors++;
        $display("FAIL reset_state c%0d: line=%b ready=%b busy=%b ce=%b done=%b par=%h mode=%b want 1 1 0 0 0 00 0",
                 i, TX_LINE, DATA_READY, BUSY, SR_CE, DONE, PAR_OUT, SHIFT_MODE);
      end
    end
    DATA_VALID = 1'b0;
    CLR = 1'b0;
    @(negedge CLK);
    checks++;
    if (TX_LINE !== 1'b1 || DATA_READY !== 1'b1 || BUSY !== 1'b0 || SR_CE !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: line=%b ready=%b busy=%b ce=%b want 1 1 0 0",
               TX_LINE, DATA_READY, BUSY, SR_CE);
    end
  endtask

  task automatic test_single_byte();
    int   loads = 0;
    int   shifts = 0;
    int   doubles = 0;
    logic prev = 1'b0;
    checks++;
    if (DATA_READY !== 1'b1) begin
      errors++;
      $display("FAIL single_ready_pre: ready=%b want 1", DATA_READY);
    end
    DATA_IN = 8'h0A;
    DATA_VALID = 1'b1;
    for (int n = 0; n <= FC + 3; n++) begin
      @(negedge CLK);
      checks++;
      if (TX_LINE !== exp_line(8'h0A, n)) begin
        errors++;
        $display("FAIL single_line n=%0d: got %b want %b", n, TX_LINE, exp_line(8'h0A, n));
      end
      checks++;
      if (DONE !== (n == FC)) begin
        errors++;
        $display("FAIL single_done n=%0d: got %b want %b", n, DONE, (n == FC));
      end
      checks++;
      if (DATA_READY !== (n >= FC + 1) || BUSY !== (n < FC + 1) ||
          SHIFT_MODE !== (n >= 1 && n < FC + 1) || PAR_OUT !== 8'h0A) begin
        errors++;
        $display("FAIL single_status n=%0d: ready=%b busy=%b mode=%b par=%h", n, DATA_READY, BUSY,
                 SHIFT_MODE, PAR_OUT);
      end
      if (SR_CE && !SHIFT_MODE) loads++;
      if (SR_CE && SHIFT_MODE) shifts++;
      if (SR_CE && prev) doubles++;
      prev = SR_CE;
      if (n == 0) begin
        DATA_VALID = 1'b0;
        DATA_IN = 8'hFF;
      end
    end
    checks++;
    if (loads != 1 || shifts != 7 || doubles != 0) begin
      errors++;
      $display("FAIL single_pulses: loads=%0d shifts=%0d doubles=%0d want 1 7 0", loads, shifts, doubles);
    end
  endtask

  task automatic test_busy_reject();
    DATA_IN = 8'h0A;
    DATA_VALID = 1'b1;
    for (int n = 0; n <= FC + 2; n++) begin
      @(negedge CLK);
      if (n <= FC + 1) begin
        checks++;
        if (PAR_OUT !== 8'h0A || DATA_READY !== (n == FC + 1)) begin
          errors++;
          $display("FAIL busy_hold n=%0d: par=%h ready=%b want 0a %b", n, PAR_OUT, DATA_READY, (n == FC + 1));
        end
      end else begin
        checks++;
        if (PAR_OUT !== 8'h55 || DATA_READY !== 1'b0 || SR_CE !== 1'b1) begin
          errors++;
          $display("FAIL busy_accept: par=%h ready=%b ce=%b want 55 0 1", PAR_OUT, DATA_READY, SR_CE);
        end
      end
      if (n == 0) DATA_IN = 8'h55;
    end
    DATA_VALID = 1'b0;
    for (int m = 1; m <= FC + 1; m++) begin
      @(negedge CLK);
      checks++;
      if (TX_LINE !== exp_line(8'h55, m)) begin
        errors++;
        $display("FAIL busy_line55 m=%0d: got %b want %b", m, TX_LINE, exp_line(8'h55, m));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic want;
    logic prev = 1'b0;
    int   doubles = 0;
    DATA_IN = 8'hFF;
    DATA_VALID = 1'b1;
    for (int n = 0; n <= 2 * FC + 3; n++) begin
      @(negedge CLK);
      want = (n < FC + 2) ? exp_line(8'hFF, n) : exp_line(8'h00, n - (FC + 2));
      checks++;
      if (TX_LINE !== want) begin
        errors++;
        $display("FAIL b2b_line n=%0d: got %b want %b", n, TX_LINE, want);
      end
      if (SR_CE && prev) doubles++;
      prev = SR_CE;
      if (n == 0) DATA_IN = 8'h00;
      if (n == FC + 2) begin
        checks++;
        if (PAR_OUT !== 8'h00 || DATA_READY !== 1'b0) begin
          errors++;
          $display("FAIL b2b_second_accept: par=%h ready=%b want 00 0", PAR_OUT, DATA_READY);
        end
        DATA_VALID = 1'b0;
      end
    end
    checks++;
    if (DATA_READY !== 1'b1 || doubles != 0) begin
      errors++;
      $display("FAIL b2b_end: ready=%b doubles=%0d want 1 0", DATA_READY, doubles);
    end
  endtask

  task automatic test_mid_frame_reset();
    DATA_IN = 8'hA5;
    DATA_VALID = 1'b1;
    for (int n = 0; n <= 19; n++) begin
      @(negedge CLK);
      if (n == 0) DATA_VALID = 1'b0;
    end
    checks++;
    if (TX_LINE !== 1'b0) begin
      errors++;
      $display("FAIL midrst_bit3: got %b want 0", TX_LINE);
    end
    #2 CLR = 1'b1;
    #1;
    checks++;
    if (TX_LINE !== 1'b1 || DATA_READY !== 1'b1 || BUSY !== 1'b0 || SR_CE !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: line=%b ready=%b busy=%b ce=%b want 1 1 0 0", TX_LINE, DATA_READY, BUSY, SR_CE);
    end
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
    @(negedge CLK);
    checks++;
    if (DATA_READY !== 1'b1 || TX_LINE !== 1'b1) begin
      errors++;
      $display("FAIL midrst_release: ready=%b line=%b want 1 1", DATA_READY, TX_LINE);
    end
    DATA_IN = 8'h3C;
    DATA_VALID = 1'b1;
    for (int n = 0; n <= FC + 1; n++) begin
      @(negedge CLK);
      checks++;
      if (TX_LINE !== exp_line(8'h3C, n) || DONE !== (n == FC)) begin
        errors++;
        $display("FAIL midrst_3c n=%0d: line=%b done=%b want %b %b", n, TX_LINE, DONE, exp_line(8'h3C, n), (n == FC));
      end
      if (n == 0) DATA_VALID = 1'b0;
    end
  endtask

`ifdef USART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] bytes [2] = '{8'h07, 8'h03};
    logic       pbit  [2] = '{1'b1, 1'b0};
    for (int t = 0; t < 2; t++) begin
      DATA_IN = bytes[t];
      DATA_VALID = 1'b1;
      for (int n = 0; n <= FC + 1; n++) begin
        @(negedge CLK);
        if (n >= 2 + 9 * CPB && n < 2 + 10 * CPB) begin
          checks++;
          if (TX_LINE !== pbit[t]) begin
            errors++;
            $display("FAIL parity_bit %h n=%0d: got %b want %b", bytes[t], n, TX_LINE, pbit[t]);
          end
        end
        checks++;
        if (DONE !== (n == 44) || DATA_READY !== (n >= 45)) begin
          errors++;
          $display("FAIL parity_len %h n=%0d: done=%b ready=%b", bytes[t], n, DONE, DATA_READY);
        end
        if (n == 0) DATA_VALID = 1'b0;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_busy_reject();
    test_back_to_back();
    test_mid_frame_reset();
`ifdef USART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
